// File: rtl/binary_clock_display_scan.sv
// ---------------------------------------------------------------------------
// binary_clock_display_scan
//
// Drives a 3-column x 6-row multiplexed binary LED matrix from the stopwatch
// time registers. Column 0 shows hours, column 1 minutes, column 2 seconds.
// Once per frame the time is captured so a frame never mixes old and new
// values. Columns are then scanned at a fixed slot rate. The column enables
// are gated by a dead-time window at the start of each slot, by a PWM
// brightness comparison and by a registered blanking input.
//
// Ports:
//   clk         board clock
//   rst_n       asynchronous active-low reset
//   Hours       binary hours (5 bits)
//   Minutes     binary minutes (6 bits)
//   Seconds     binary seconds (6 bits)
//   Brightness  on-duty numerator out of 2^PWM_BITS, compared live
//   Blank       forces the display dark while high (one cycle of latency)
//   ColEn       one-hot active-high column enable
//   RowData     active-high row pattern for the current column, bit0 = LSB
//   FrameStart  single-cycle pulse on the first cycle of each frame
// ---------------------------------------------------------------------------
module binary_clock_display_scan #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          Hours,
  input  logic [5:0]          Minutes,
  input  logic [5:0]          Seconds,
  input  logic [PWM_BITS-1:0] Brightness,
  input  logic                Blank,
  output logic [2:0]          ColEn,
  output logic [5:0]          RowData,
  output logic                FrameStart
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_END = DIV_W'(DEAD_CYCLES);

  typedef enum logic [1:0] {
    COL_HOURS   = 2'd0,
    COL_MINUTES = 2'd1,
    COL_SECONDS = 2'd2
  } col_e;

  logic [DIV_W-1:0]    div_q, div_d;
  col_e                col_q, col_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [5:0]          snapMinutes_q, snapMinutes_d;
  logic [5:0]          snapSeconds_q, snapSeconds_d;
  logic [5:0]          rowData_q, rowData_d;
  logic                frameStart_q, frameStart_d;
  logic                loadPending_q, loadPending_d;
  logic                blank_q;

  logic slotEnd;
  logic frameBoundary;

  assign slotEnd = (div_q == DIV_LAST);

  // The first edge after reset is treated as a frame boundary, so the display
  // restarts cleanly with a fresh snapshot instead of showing cleared values.
  assign frameBoundary = loadPending_q || (slotEnd && (col_q == COL_SECONDS));

  // Next-state logic for the slot divider, column sequencer and snapshot.
  // The hours snapshot has no register of its own: hours go straight into
  // RowData at the frame boundary and are only ever shown in column 0, which
  // begins on that same edge. Minutes and seconds are held until their
  // slots come up.
  always_comb begin
    div_d         = div_q + DIV_W'(1);
    col_d         = col_q;
    pwm_d         = pwm_q + PWM_BITS'(1);
    snapMinutes_d = snapMinutes_q;
    snapSeconds_d = snapSeconds_q;
    rowData_d     = rowData_q;
    frameStart_d  = 1'b0;
    loadPending_d = 1'b0;

    if (frameBoundary) begin
      div_d         = '0;
      col_d         = COL_HOURS;
      snapMinutes_d = Minutes;
      snapSeconds_d = Seconds;
      rowData_d     = {1'b0, Hours};
      frameStart_d  = 1'b1;
    end else if (slotEnd) begin
      div_d = '0;
      case (col_q)
        COL_HOURS: begin
          col_d     = COL_MINUTES;
          rowData_d = snapMinutes_q;
        end
        COL_MINUTES: begin
          col_d     = COL_SECONDS;
          rowData_d = snapSeconds_q;
        end
        default: begin
          col_d = COL_HOURS;
        end
      endcase
    end
  end

  // All scan state is registered here, so RowData and FrameStart come
  // straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      col_q         <= COL_HOURS;
      pwm_q         <= '0;
      snapMinutes_q <= '0;
      snapSeconds_q <= '0;
      rowData_q     <= '0;
      frameStart_q  <= 1'b0;
      loadPending_q <= 1'b1;
      blank_q       <= 1'b0;
    end else begin
      div_q         <= div_d;
      col_q         <= col_d;
      pwm_q         <= pwm_d;
      snapMinutes_q <= snapMinutes_d;
      snapSeconds_q <= snapSeconds_d;
      rowData_q     <= rowData_d;
      frameStart_q  <= frameStart_d;
      loadPending_q <= loadPending_d;
      blank_q       <= Blank;
    end
  end

  // Column enable decode. It reads only registered state, apart from
  // Brightness, which is compared live. The dead window at the start of each
  // slot lets the row drivers settle before a column lights, which prevents
  // ghosting.
  always_comb begin
    ColEn = 3'b000;
    if (!blank_q && (div_q >= DEAD_END) && (pwm_q < Brightness)) begin
      case (col_q)
        COL_HOURS:   ColEn = 3'b001;
        COL_MINUTES: ColEn = 3'b010;
        COL_SECONDS: ColEn = 3'b100;
        default:     ColEn = 3'b000;
      endcase
    end
  end

  assign RowData    = rowData_q;
  assign FrameStart = frameStart_q;

endmodule
